output_writeback: RTL and testbench

Requantizing write-back stage between the accumulator array and the output SRAM. It accepts signed accumulator results on an AXI-Stream slave and applies a Q31 multiplier, a rounding right shift, a zero-point add and saturation. Each result is written to consecutive output-SRAM addresses. After `out_size` results have been written, it raises `start_output` so the AXI-Stream output stage can drain the SRAM to the host.

---
 rtl/npu_defs.sv | 29 ++
 rtl/output_writeback_if.sv | 12 +
 rtl/output_writeback_requant_pipe.sv | 64 ++++++
 rtl/output_writeback.sv | 135 +++++++++++++
 tb/tb_output_writeback.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_defs.sv
// rtl/npu_defs.sv - shared state encodings and requantization constants for output_writeback
package npu_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

  localparam int Q31_FRAC_BITS = 31;
  localparam int Q31_ROUND_BIT = 30;
  localparam int REQ_Y_WIDTH   = 34;
  localparam logic signed [REQ_Y_WIDTH-1:0] REQ_Y_ONE = 34'sd1;

  // Half an output LSB at the chosen shift, giving round-half-toward-+inf.
  function automatic logic signed [63:0] q31_round(input logic [4:0] shift);
    return 64'sd1 <<< (Q31_ROUND_BIT + int'(shift));
  endfunction

  function automatic logic signed [REQ_Y_WIDTH-1:0] sat_max(input int width);
    return (REQ_Y_ONE <<< (width - 1)) - REQ_Y_ONE;
  endfunction

  function automatic logic signed [REQ_Y_WIDTH-1:0] sat_min(input int width);
    return -(REQ_Y_ONE <<< (width - 1));
  endfunction

endpackage

// File: rtl/output_writeback_if.sv
// rtl/output_writeback_if.sv - accumulator result stream into the write-back stage
interface output_writeback_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] tdata;
  logic                         tvalid;
  logic                         tready;
  logic                         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/output_writeback_requant_pipe.sv
// rtl/output_writeback_requant_pipe.sv - multiply / round-shift+zp / saturate pipeline
// OUTPUT_WB_RELU_EN: lower clamp bound becomes the zero point (fused ReLU).
module requant_pipe
  import npu_defs::*;
#(
  parameter int ACC_WIDTH    = 32,
  parameter int SRAM_WIDTH_O = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [ACC_WIDTH-1:0]    in_data,
  input  logic signed [31:0]             quant_mult,
  input  logic        [4:0]              quant_shift,
  input  logic signed [SRAM_WIDTH_O-1:0] zero_point,
  output logic                           out_valid,
  output logic signed [SRAM_WIDTH_O-1:0] out_data
);

  localparam logic signed [REQ_Y_WIDTH-1:0] SAT_MAX = sat_max(SRAM_WIDTH_O);
  localparam logic signed [REQ_Y_WIDTH-1:0] SAT_MIN = sat_min(SRAM_WIDTH_O);

  logic                          v1, v2;
  logic signed [63:0]            p1;
  logic signed [REQ_Y_WIDTH-1:0] y2;
  logic signed [63:0]            p_rnd;
  logic signed [REQ_Y_WIDTH-1:0] y_next;
  logic signed [REQ_Y_WIDTH-1:0] lo_bound;

  // Config inputs are held constant for the whole layer, so they feed each stage directly.
  always_comb begin
    p_rnd  = p1 + q31_round(quant_shift);
    y_next = REQ_Y_WIDTH'(p_rnd >>> (Q31_FRAC_BITS + int'(quant_shift)))
           + REQ_Y_WIDTH'(zero_point);
`ifdef OUTPUT_WB_RELU_EN
    lo_bound = REQ_Y_WIDTH'(zero_point);
`else
    lo_bound = SAT_MIN;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      p1        <= '0;
      y2        <= '0;
      out_data  <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) p1 <= 64'(in_data) * 64'(quant_mult);
      if (v1)       y2 <= y_next;
      if (v2) begin
        if (y2 > SAT_MAX)       out_data <= SRAM_WIDTH_O'(SAT_MAX);
        else if (y2 < lo_bound) out_data <= SRAM_WIDTH_O'(lo_bound);
        else                    out_data <= SRAM_WIDTH_O'(y2);
      end
    end
  end

endmodule

// File: rtl/output_writeback.sv
// rtl/output_writeback.sv - requantizing write-back of accumulator results into output SRAM
// OUTPUT_WB_RELU_EN selects a fused-ReLU lower clamp inside requant_pipe.
module output_writeback
  import npu_defs::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int ACC_WIDTH      = 32,
  parameter int SRAM_WIDTH_O   = 16,
  parameter int MAX_ADDR_WIDTH = 14
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  output_writeback_if.slave              s_axis,
  input  logic                           start,
  input  logic                           clear,
  input  logic        [MAX_ADDR_WIDTH-1:0] out_size,
  input  logic signed [31:0]             quant_mult,
  input  logic        [4:0]              quant_shift,
  input  logic signed [SRAM_WIDTH_O-1:0] out_zero_point,
  output logic                           sram_out_we,
  output logic        [ADDR_WIDTH-1:0]   sram_out_addr,
  output logic signed [SRAM_WIDTH_O-1:0] sram_out_data_in,
  output logic                           start_output,
  output logic                           busy,
  output logic                           err_tlast
);

  localparam logic [MAX_ADDR_WIDTH-1:0] CNT_ONE = MAX_ADDR_WIDTH'(1);

  wb_state_t                      state;
  logic [MAX_ADDR_WIDTH-1:0]      cfg_size;
  logic signed [31:0]             cfg_mult;
  logic [4:0]                     cfg_shift;
  logic signed [SRAM_WIDTH_O-1:0] cfg_zp;
  logic [MAX_ADDR_WIDTH-1:0]      in_cnt;
  logic [MAX_ADDR_WIDTH-1:0]      wr_cnt;
  logic                           tready_q;
  logic                           accept;
  logic                           last_beat;
  logic                           pipe_valid;
  logic signed [SRAM_WIDTH_O-1:0] pipe_data;

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid && tready_q;
  assign last_beat     = (in_cnt == cfg_size - CNT_ONE);

  requant_pipe #(
    .ACC_WIDTH    (ACC_WIDTH),
    .SRAM_WIDTH_O (SRAM_WIDTH_O)
  ) u_requant_pipe (
    .clk         (s_axis_aclk),
    .rst_n       (s_axis_aresetn),
    .in_valid    (accept),
    .in_data     (s_axis.tdata),
    .quant_mult  (cfg_mult),
    .quant_shift (cfg_shift),
    .zero_point  (cfg_zp),
    .out_valid   (pipe_valid),
    .out_data    (pipe_data)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state            <= ST_IDLE;
      cfg_size         <= '0;
      cfg_mult         <= '0;
      cfg_shift        <= '0;
      cfg_zp           <= '0;
      in_cnt           <= '0;
      wr_cnt           <= '0;
      tready_q         <= 1'b0;
      sram_out_we      <= 1'b0;
      sram_out_addr    <= '0;
      sram_out_data_in <= '0;
      start_output     <= 1'b0;
      busy             <= 1'b0;
      err_tlast        <= 1'b0;
    end else begin
      sram_out_we <= pipe_valid;
      if (pipe_valid) begin
        sram_out_addr    <= wr_cnt[ADDR_WIDTH-1:0];
        sram_out_data_in <= pipe_data;
        wr_cnt           <= wr_cnt + CNT_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_size  <= out_size;
            cfg_mult  <= quant_mult;
            cfg_shift <= quant_shift;
            cfg_zp    <= out_zero_point;
            in_cnt    <= '0;
            wr_cnt    <= '0;
            err_tlast <= 1'b0;
            if (out_size == '0) begin
              state        <= ST_DONE;
              start_output <= 1'b1;
            end else begin
              state    <= ST_RUN;
              tready_q <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + CNT_ONE;
            // An early tlast only flags the error; the layer still runs to out_size beats.
            if (s_axis.tlast != last_beat) err_tlast <= 1'b1;
            if (last_beat) begin
              state    <= ST_DRAIN;
              tready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (sram_out_we && (wr_cnt == cfg_size)) begin
            state        <= ST_DONE;
            start_output <= 1'b1;
            busy         <= 1'b0;
          end
        end
        ST_DONE: begin
          if (clear) begin
            state        <= ST_IDLE;
            start_output <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// tb/tb_output_writeback.sv - self-checking bench for output_writeback with a requant reference model
module tb_output_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic [13:0]        out_size = '0;
  logic signed [31:0] quant_mult = '0;
  logic [4:0]         quant_shift = '0;
  logic signed [15:0] out_zero_point = '0;
  logic               sram_out_we;
  logic [12:0]        sram_out_addr;
  logic signed [15:0] sram_out_data_in;
  logic               start_output;
  logic               busy;
  logic               err_tlast;

  output_writeback_if #(.DATA_WIDTH(32)) s_axis ();

  output_writeback dut (
    .s_axis_aclk      (clk),
    .s_axis_aresetn   (rst_n),
    .s_axis           (s_axis),
    .start            (start),
    .clear            (clear),
    .out_size         (out_size),
    .quant_mult       (quant_mult),
    .quant_shift      (quant_shift),
    .out_zero_point   (out_zero_point),
    .sram_out_we      (sram_out_we),
    .sram_out_addr    (sram_out_addr),
    .sram_out_data_in (sram_out_data_in),
    .start_output     (start_output),
    .busy             (busy),
    .err_tlast        (err_tlast)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  logic signed [31:0] acc_arr[32];
  int first_acc;
  int last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_out_we) begin
      wr_addr_q.push_back(int'(sram_out_addr));
      wr_data_q.push_back(int'(sram_out_data_in));
      wr_cyc_q.push_back(cyc);
    end
  end

  // Reference: floor((acc*mult + 2^(30+s)) / 2^(31+s)) + zp, clamped to the int16 range.
  function automatic int ref_q(input int acc, input int mult, input int shift, input int zp);
    longint p, y, lo;
    p = longint'(acc) * longint'(mult);
    y = ((p + (longint'(1) <<< (30 + shift))) >>> (31 + shift)) + longint'(zp);
`ifdef OUTPUT_WB_RELU_EN
    lo = longint'(zp);
`else
    lo = -32768;
`endif
    if (y > 32767) y = 32767;
    else if (y < lo) y = lo;
    return int'(y);
  endfunction

  task automatic begin_layer(input int n, input int mult, input int shift, input int zp);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    out_size = 14'(n);
    quant_mult = mult;
    quant_shift = 5'(shift);
    out_zero_point = 16'(zp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int tlast_beat, input int gap_pct, output bit ok);
    int to;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis.tvalid = 1'b1;
      s_axis.tdata = acc_arr[i];
      s_axis.tlast = (i == tlast_beat);
      to = 0;
      forever begin
        @(negedge clk);
        if (s_axis.tready) break;
        to++;
        if (to > 100) break;
      end
      if (to > 100) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (i == 0) first_acc = cyc;
      last_acc = cyc;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk); #1;
      if (start_output) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_axis.tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_axis.tready); end
    checks++; if (sram_out_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", sram_out_we); end
    checks++; if (sram_out_addr !== 13'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", sram_out_addr); end
    checks++; if (sram_out_data_in !== 16'sd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", sram_out_data_in); end
    checks++; if (start_output !== 1'b0) begin failures++; $display("FAIL reset_start_output got=%b exp=0", start_output); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_tlast !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_tlast); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int exp_c[4] = '{50, -50, 2, -1};
    int k;
    bit ok;
    acc_arr[0] = 100; acc_arr[1] = -100; acc_arr[2] = 3; acc_arr[3] = -3;
    begin_layer(4, 32'h40000000, 0, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
    send_beats(4, 3, 0, ok);
    wait_done(k);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept_timeout got=%b exp=1", ok); end
    checks++; if (k !== 4) begin failures++; $display("FAIL basic_done_latency got=%0d exp=4", k); end
    checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL basic_wr_count got=%0d exp=4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== i) begin failures++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], i); end
      checks++; if (wr_data_q[i] !== exp_c[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, wr_data_q[i], exp_c[i]); end
      checks++; if (wr_data_q[i] !== ref_q(acc_arr[i], 32'h40000000, 0, 0)) begin failures++; $display("FAIL basic_model[%0d] got=%0d exp=%0d", i, wr_data_q[i], ref_q(acc_arr[i], 32'h40000000, 0, 0)); end
    end
    if (wr_cyc_q.size() == 4) begin
      checks++; if (wr_cyc_q[0] - first_acc !== 3) begin failures++; $display("FAIL basic_write_latency got=%0d exp=3", wr_cyc_q[0] - first_acc); end
      checks++; if (wr_cyc_q[3] - wr_cyc_q[0] !== 3) begin failures++; $display("FAIL basic_throughput got=%0d exp=3", wr_cyc_q[3] - wr_cyc_q[0]); end
    end
    checks++; if (err_tlast !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_tlast); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
    do_clear();
    checks++; if (start_output !== 1'b0) begin failures++; $display("FAIL basic_clear got=%b exp=0", start_output); end
  endtask

  task automatic test_saturation();
    int exp_c[2] = '{32767, -32768};
    int k;
    bit ok;
    acc_arr[0] = 32'h7FFFFFFF; acc_arr[1] = 32'h80000000;
    begin_layer(2, 32'h7FFFFFFF, 0, 0);
    send_beats(2, 1, 0, ok);
    wait_done(k);
    checks++; if (wr_data_q.size() !== 2) begin failures++; $display("FAIL sat_count got=%0d exp=2", wr_data_q.size()); end
    for (int i = 0; i < 2 && i < wr_data_q.size(); i++) begin
      checks++; if (wr_data_q[i] !== exp_c[i]) begin failures++; $display("FAIL sat_data[%0d] got=%0d exp=%0d", i, wr_data_q[i], exp_c[i]); end
    end
    do_clear();
  endtask

  task automatic test_relu();
    int k;
    int exp_v;
    bit ok;
`ifdef OUTPUT_WB_RELU_EN
    exp_v = 10;
`else
    exp_v = -40;
`endif
    acc_arr[0] = -100;
    begin_layer(1, 32'h40000000, 0, 10);
    send_beats(1, 0, 0, ok);
    wait_done(k);
    checks++; if (wr_data_q.size() !== 1) begin failures++; $display("FAIL relu_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== exp_v) begin failures++; $display("FAIL relu_data got=%0d exp=%0d", wr_data_q[0], exp_v); end
    end
    do_clear();
  endtask

  task automatic test_random();
    int k, n, mult, shift, zp, e;
    bit ok;
    for (int l = 0; l < 6; l++) begin
      n = $urandom_range(1, 12);
      mult = int'($urandom);
      shift = $urandom_range(0, 31);
      zp = $urandom_range(0, 200) - 100;
      for (int i = 0; i < n; i++) acc_arr[i] = (l < 3) ? $urandom : ($urandom_range(0, 4000) - 2000);
      begin_layer(n, mult, shift, zp);
      send_beats(n, n - 1, 20, ok);
      wait_done(k);
      checks++; if (k < 1 || wr_data_q.size() !== n) begin failures++; $display("FAIL rand_count l=%0d got=%0d exp=%0d", l, wr_data_q.size(), n); end
      for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
        e = ref_q(acc_arr[i], mult, shift, zp);
        checks++; if (wr_data_q[i] !== e || wr_addr_q[i] !== i) begin
          failures++; $display("FAIL rand_data l=%0d i=%0d got=%0d@%0d exp=%0d@%0d", l, i, wr_data_q[i], wr_addr_q[i], e, i);
        end
      end
      checks++; if (err_tlast !== 1'b0) begin failures++; $display("FAIL rand_err l=%0d got=%b exp=0", l, err_tlast); end
      do_clear();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit tr_hi = 1'b0;
    int k, e;
    for (int i = 0; i < 8; i++) acc_arr[i] = $urandom;
    begin_layer(8, 32'h12345678, 3, -7);
    send_beats(8, 7, 50, ok);
    for (int j = 0; j < 20 && !start_output; j++) begin
      @(negedge clk);
      if (s_axis.tready) tr_hi = 1'b1;
    end
    wait_done(k);
    checks++; if (tr_hi !== 1'b0) begin failures++; $display("FAIL b2b_tready_drain got=%b exp=0", tr_hi); end
    checks++; if (wr_addr_q.size() !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", wr_addr_q.size()); end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      e = ref_q(acc_arr[i], 32'h12345678, 3, -7);
      checks++; if (wr_addr_q[i] !== i || wr_data_q[i] !== e) begin
        failures++; $display("FAIL b2b_write[%0d] got=%0d@%0d exp=%0d@%0d", i, wr_data_q[i], wr_addr_q[i], e, i);
      end
    end
    do_clear();
  endtask

  task automatic test_tlast_fault();
    bit ok;
    int k;
    for (int i = 0; i < 4; i++) acc_arr[i] = $urandom_range(0, 1000);
    begin_layer(4, 32'h40000000, 0, 0);
    send_beats(4, 1, 0, ok);
    wait_done(k);
    checks++; if (err_tlast !== 1'b1) begin failures++; $display("FAIL tlast_early_err got=%b exp=1", err_tlast); end
    checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL tlast_early_count got=%0d exp=4", wr_addr_q.size()); end
    do_clear();
    begin_layer(3, 32'h40000000, 0, 0);
    checks++; if (err_tlast !== 1'b0) begin failures++; $display("FAIL tlast_err_cleared got=%b exp=0", err_tlast); end
    send_beats(3, -1, 0, ok);
    wait_done(k);
    checks++; if (err_tlast !== 1'b1) begin failures++; $display("FAIL tlast_missing_err got=%b exp=1", err_tlast); end
    do_clear();
  endtask

  task automatic test_zero_size();
    begin_layer(0, 32'h40000000, 0, 0);
    checks++; if (start_output !== 1'b1) begin failures++; $display("FAIL zero_start_output got=%b exp=1", start_output); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_addr_q.size()); end
  endtask

  task automatic test_clear_start();
    clear = 1'b1;
    start = 1'b1;
    out_size = 14'd1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    checks++; if (start_output !== 1'b0) begin failures++; $display("FAIL clrstart_idle got=%b exp=0", start_output); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || s_axis.tready !== 1'b0) begin failures++; $display("FAIL clrstart_ignored got=%b%b exp=00", busy, s_axis.tready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    for (int i = 0; i < 6; i++) acc_arr[i] = $urandom;
    begin_layer(6, 32'h30000000, 1, 5);
    send_beats(2, -1, 0, ok);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (s_axis.tready !== 1'b0 || busy !== 1'b0 || start_output !== 1'b0 || err_tlast !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", s_axis.tready, busy, start_output, err_tlast);
    end
    checks++; if (sram_out_we !== 1'b0 || sram_out_addr !== 13'd0 || sram_out_data_in !== 16'sd0) begin
      failures++; $display("FAIL rstmid_wport got=%b/%0d/%0d exp=0/0/0", sram_out_we, sram_out_addr, sram_out_data_in);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL rstmid_no_writes got=%0d exp=0", wr_addr_q.size()); end
    for (int i = 0; i < 2; i++) acc_arr[i] = $urandom;
    begin_layer(2, 32'h30000000, 1, 5);
    send_beats(2, 1, 0, ok);
    wait_done(k);
    checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL rstmid_restart_count got=%0d exp=2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== i || wr_data_q[i] !== ref_q(acc_arr[i], 32'h30000000, 1, 5)) begin
        failures++; $display("FAIL rstmid_restart[%0d] got=%0d@%0d exp=%0d@%0d", i, wr_data_q[i], wr_addr_q[i], ref_q(acc_arr[i], 32'h30000000, 1, 5), i);
      end
    end
    do_clear();
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    s_axis.tlast = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_random();
    test_back_to_back();
    test_tlast_fault();
    test_zero_size();
    test_clear_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
